noc_request_agent: RTL and testbench
====================================

NOC_REQUEST_AGENT -- requirements
Module: noc_request_agent

Interface
REQ-001 Parameter NUM_AGENTS, default 4: number of requesting input queues; SHALL be >= 2.
REQ-002 Parameter DATA_W, default 32: flit width in bits.
REQ-003 Parameter FIFO_DEPTH, default 4: entries per agent queue; SHALL be a power of 2, >= 2.
REQ-004 Parameter STARV_THRESH, default 3: wait-cycle count at which starvation is flagged; SHALL be 1..14.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  NUM_AGENTS  per-agent flit offered.
REQ-008 in_data  input  NUM_AGENTS*DATA_W  per-agent flit; agent i occupies bits [i*DATA_W +: DATA_W].
REQ-009 in_ready  output  NUM_AGENTS  per-agent queue can accept.
REQ-010 request  output  NUM_AGENTS  request vector driven to the round-robin arbiter.
REQ-011 grant  input  NUM_AGENTS  grant vector from the arbiter, expected one-hot or zero, same cycle as request.
REQ-012 out_valid  output  1  granted flit present.
REQ-013 out_data  output  DATA_W  granted flit.
REQ-014 out_src  output  $clog2(NUM_AGENTS)  index of the agent the flit came from.
REQ-015 out_ready  input  1  downstream accepts flit.
REQ-016 starve  output  NUM_AGENTS  per-agent starvation flag.
REQ-017 grant_err  output  1  sticky protocol-error flag.

Function
REQ-018 Each agent SHALL own a FIFO of FIFO_DEPTH entries; push when in_valid[i] & in_ready[i]; in_ready[i] = !full[i] & !rst.
REQ-019 Push on a full FIFO SHALL NOT occur; a pop in the same cycle does not free space for a push in that cycle (in_ready from registered occupancy only).
REQ-020 Output stage SHALL be a single register (out_valid/out_data/out_src); it is "free" when !out_valid or (out_valid & out_ready).
REQ-021 request[i] SHALL be combinational: FIFO i non-empty (registered count) & output stage free & !rst.
REQ-022 A flit pushed at edge t SHALL make request[i] eligible from cycle t+1 (no write-through).
REQ-023 Accepted grant: grant[i] & request[i] at edge t pops FIFO i head into output register; out_valid=1, out_src=i from cycle t+1 (1-cycle latency).
REQ-024 Output register SHALL hold value stable while out_valid & !out_ready; clear out_valid on out_ready with no new accepted grant.
REQ-025 out_ready and a new accepted grant in the same cycle SHALL load the new flit with out_valid staying 1 (back-to-back, one flit per cycle).
REQ-026 grant[i] with request[i]=0 SHALL be ignored (no pop) and SHALL set grant_err.
REQ-027 grant with more than one bit set SHALL set grant_err; only the lowest-index bit with request set is accepted.
REQ-028 grant_err SHALL remain 1 until reset.
REQ-029 Push and pop of the same FIFO in one cycle SHALL both take effect; occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-030 Per-agent wait counter, 4 bits: increments when request[i] & !accepted grant for i, saturates at 15, clears to 0 on accepted grant for i or when FIFO i empty.
REQ-031 starve[i] SHALL be registered: 1 when wait counter >= STARV_THRESH, else 0.
REQ-032 Flits from one agent SHALL leave in push order; no flit is dropped or duplicated.

Reset
REQ-033 rst at an edge SHALL empty all FIFOs (pointers/counts 0), clear wait counters, out_valid=0, out_data=0, out_src=0, starve=0, grant_err=0.
REQ-034 While rst=1: request=0, in_ready=0; in-flight flits and output register content are discarded, including reset asserted mid-stall.
REQ-035 First cycle after rst deasserts: in_ready all 1, request all 0.

Verification
REQ-036 Push 0xA0 to agent 0 at t0, grant=0001 at t1 -> request=0001 at t1, out_valid=1, out_data=0xA0, out_src=0 at t2.
REQ-037 Fill agent 2 with 4 flits, out_ready=1, grant=0100 each cycle -> 4 consecutive out_valid cycles in order; in_ready[2]=0 only while count=4.
REQ-038 out_valid=1, out_ready=0 for 5 cycles, agent 1 non-empty -> request=0000, output stable; starve[1] unchanged (counter not incrementing while request=0).
REQ-039 Agent 3 requesting, grant=0000 for 4 cycles -> starve[3]=1 after counter reaches 3; accepted grant -> starve[3]=0 one cycle later.
REQ-040 grant=0011 with request=0011 -> agent 0 popped, agent 1 retained, grant_err=1 sticky; grant=1000 with request[3]=0 -> no pop, grant_err stays 1.
REQ-041 rst pulsed with 3 flits queued and out_valid=1 -> next cycle out_valid=0, request=0000, all FIFOs empty, grant_err=0.

Source files
------------

// File: rtl/noc_request_agent.sv
// Per-agent input FIFOs feeding a single output register through an external arbiter.
// Tracks per-agent wait time for starvation flagging and latches grant protocol errors.
module noc_request_agent #(
  parameter int unsigned NUM_AGENTS   = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARV_THRESH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_AGENTS-1:0]         in_valid,
  input  logic [NUM_AGENTS*DATA_W-1:0]  in_data,
  output logic [NUM_AGENTS-1:0]         in_ready,
  output logic [NUM_AGENTS-1:0]         request,
  input  logic [NUM_AGENTS-1:0]         grant,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [$clog2(NUM_AGENTS)-1:0] out_src,
  input  logic                          out_ready,
  output logic [NUM_AGENTS-1:0]         starve,
  output logic                          grant_err
);

  localparam int unsigned SrcW = $clog2(NUM_AGENTS);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q   [NUM_AGENTS][FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q [NUM_AGENTS];
  logic [PtrW-1:0]   wr_ptr_d [NUM_AGENTS];
  logic [PtrW-1:0]   rd_ptr_q [NUM_AGENTS];
  logic [PtrW-1:0]   rd_ptr_d [NUM_AGENTS];
  logic [CntW-1:0]   cnt_q    [NUM_AGENTS];
  logic [CntW-1:0]   cnt_d    [NUM_AGENTS];
  logic [3:0]        wcnt_q   [NUM_AGENTS];
  logic [3:0]        wcnt_d   [NUM_AGENTS];

  logic [NUM_AGENTS-1:0] starve_q, starve_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic [SrcW-1:0]       out_src_q, out_src_d;
  logic                  grant_err_q, grant_err_d;

  logic                  out_free;
  logic [NUM_AGENTS-1:0] push;
  logic [NUM_AGENTS-1:0] accept;
  logic                  acc_found;
  logic [SrcW-1:0]       acc_src;
  logic [DATA_W-1:0]     acc_data;
  logic                  multi_grant;
  logic                  bad_grant;

  // Handshakes use registered occupancy only, so a same-cycle pop never frees a slot.
  always_comb begin
    out_free  = !out_valid_q || out_ready;
    in_ready  = '0;
    request   = '0;
    push      = '0;
    accept    = '0;
    acc_found = 1'b0;
    acc_src   = '0;
    acc_data  = '0;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      in_ready[i] = !rst && (cnt_q[i] != CntW'(FIFO_DEPTH));
      request[i]  = !rst && (cnt_q[i] != '0) && out_free;
      push[i]     = in_valid[i] && in_ready[i];
    end
    // Lowest-index granted requester wins if the arbiter sends more than one bit.
    for (int i = 0; i < NUM_AGENTS; i++) begin
      if (!acc_found && grant[i] && request[i]) begin
        accept[i] = 1'b1;
        acc_found = 1'b1;
        acc_src   = SrcW'(i);
        acc_data  = mem_q[i][rd_ptr_q[i]];
      end
    end
    multi_grant = (grant & (grant - 1'b1)) != '0;
    bad_grant   = |(grant & ~request);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    wcnt_d      = wcnt_q;
    starve_d    = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    grant_err_d = grant_err_q || multi_grant || bad_grant;
    for (int i = 0; i < NUM_AGENTS; i++) begin
      if (push[i]) begin
        wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
      end
      if (accept[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
      end
      if (push[i] && !accept[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!push[i] && accept[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
      // Counter only advances while actually requesting; a stalled output freezes it.
      if (accept[i] || (cnt_q[i] == '0)) begin
        wcnt_d[i] = '0;
      end else if (request[i] && (wcnt_q[i] != 4'hF)) begin
        wcnt_d[i] = wcnt_q[i] + 1'b1;
      end
      starve_d[i] = wcnt_d[i] >= 4'(STARV_THRESH);
    end
    if (acc_found) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data;
      out_src_d   = acc_src;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_AGENTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        wcnt_q[i]   <= '0;
      end
      starve_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      grant_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      starve_q    <= starve_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      grant_err_q <= grant_err_d;
    end
  end

  // Storage needs no reset; occupancy counters define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_AGENTS; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign starve    = starve_q;
  assign grant_err = grant_err_q;

endmodule

// File: tb/tb_noc_request_agent.sv
// Scenario bench for noc_request_agent: per-agent queue model feeds an output scoreboard,
// scenario tasks check handshakes, starvation, grant errors and reset inline.
module tb_noc_request_agent;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [127:0] in_data;
  logic [3:0]  in_ready;
  logic [3:0]  request;
  logic [3:0]  grant;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_src;
  logic        out_ready;
  logic [3:0]  starve;
  logic        grant_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq [4][$];
  logic [33:0] sb [$];
  logic        m_ov = 1'b0;

  noc_request_agent #(
    .NUM_AGENTS  (4),
    .DATA_W      (32),
    .FIFO_DEPTH  (4),
    .STARV_THRESH(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .request  (request),
    .grant    (grant),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_src  (out_src),
    .out_ready(out_ready),
    .starve   (starve),
    .grant_err(grant_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_flit(input int a, input logic [31:0] d);
    in_valid[a]       = 1'b1;
    in_data[a*32 +: 32] = d;
  endtask

  // Advance one clock; model the queues and compare every flit that leaves the DUT.
  task automatic cycle();
    logic [3:0]  req;
    logic [3:0]  rdy;
    logic [33:0] exp;
    int          acc;
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      sb.delete();
      m_ov = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        req[i] = (mq[i].size() != 0) && (!m_ov || out_ready);
        rdy[i] = mq[i].size() < 4;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_flit: got src %0d data %h, expected none", out_src,
                   out_data);
        end else begin
          exp = sb.pop_front();
          if ({out_src, out_data} !== exp) begin
            errors++;
            $display("FAIL sb_flit: got %h expected %h", {out_src, out_data}, exp);
          end
        end
      end
      acc = -1;
      for (int i = 0; i < 4; i++) if (acc < 0 && grant[i] && req[i]) acc = i;
      if (acc >= 0) begin
        sb.push_back({2'(acc), mq[acc].pop_front()});
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      for (int i = 0; i < 4; i++) if (in_valid[i] && rdy[i]) mq[i].push_back(in_data[i*32 +: 32]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; in_data = '0; grant = '0; out_ready = 1'b0;
    #1;
    checks++;
    if ({request, in_ready} !== 8'h00) begin
      errors++; $display("FAIL rst_handshake: got %b expected 00000000", {request, in_ready});
    end
    cycle(); cycle();
    checks++;
    if ({out_valid, out_data, out_src, starve, grant_err} !== '0) begin
      errors++;
      $display("FAIL rst_state: got v%b d%h s%0d st%b e%b expected all zero", out_valid,
               out_data, out_src, starve, grant_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, request} !== 8'hF0) begin
      errors++; $display("FAIL rst_release: got %b expected 11110000", {in_ready, request});
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    set_flit(0, 32'hA0);
    cycle();
    in_valid = '0; grant = 4'b0001;
    #1;
    checks++;
    if (request !== 4'b0001) begin
      errors++; $display("FAIL basic_req: got %b expected 0001", request);
    end
    cycle();
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd0, 32'hA0}) begin
      errors++;
      $display("FAIL basic_out: got v%b s%0d d%h expected v1 s0 d000000a0", out_valid, out_src,
               out_data);
    end
    grant = '0;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_clear: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      set_flit(2, 32'h200 + k);
      #1;
      checks++;
      if (in_ready[2] !== 1'b1) begin
        errors++; $display("FAIL fill_ready_%0d: got %b expected 1", k, in_ready[2]);
      end
      cycle();
    end
    in_valid = '0; grant = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (in_ready[2] !== (k != 0)) begin
        errors++; $display("FAIL fill_drain_ready_%0d: got %b expected %b", k, in_ready[2], k != 0);
      end
      cycle();
      checks++;
      if ({out_valid, out_data} !== {1'b1, 32'h200 + k}) begin
        errors++;
        $display("FAIL fill_out_%0d: got v%b d%h expected v1 d%h", k, out_valid, out_data,
                 32'h200 + k);
      end
    end
    grant = '0;
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL fill_end: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_stall();
    set_flit(0, 32'hB0); set_flit(1, 32'hB1);
    cycle();
    in_valid = '0; grant = 4'b0001; out_ready = 1'b0;
    cycle();
    grant = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (request !== 4'b0000) begin
        errors++; $display("FAIL stall_req_%0d: got %b expected 0000", k, request);
      end
      cycle();
      checks++;
      if ({out_valid, out_src, out_data, starve[1]} !== {1'b1, 2'd0, 32'hB0, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got v%b s%0d d%h st%b expected v1 s0 d000000b0 st0", k,
                 out_valid, out_src, out_data, starve[1]);
      end
    end
    out_ready = 1'b1; grant = 4'b0010;
    #1;
    checks++;
    if (request !== 4'b0010) begin
      errors++; $display("FAIL stall_resume_req: got %b expected 0010", request);
    end
    cycle();
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd1, 32'hB1}) begin
      errors++;
      $display("FAIL stall_resume_out: got v%b s%0d d%h expected v1 s1 d000000b1", out_valid,
               out_src, out_data);
    end
    grant = '0;
    cycle();
  endtask

  task automatic test_starve();
    set_flit(3, 32'hC3);
    cycle();
    in_valid = '0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++;
      if (starve[3] !== (k >= 3)) begin
        errors++; $display("FAIL starve_wait_%0d: got %b expected %b", k, starve[3], k >= 3);
      end
    end
    grant = 4'b1000;
    cycle();
    checks++;
    if ({starve[3], out_valid, out_src} !== {1'b0, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL starve_clear: got st%b v%b s%0d expected st0 v1 s3", starve[3], out_valid,
               out_src);
    end
    grant = '0;
    cycle();
  endtask

  task automatic test_back_to_back();
    set_flit(0, 32'h10); set_flit(1, 32'h11); set_flit(2, 32'h12);
    cycle();
    in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      grant = 4'b0001 << k;
      cycle();
      checks++;
      if ({out_valid, out_src, out_data} !== {1'b1, 2'(k), 32'h10 + k}) begin
        errors++;
        $display("FAIL b2b_%0d: got v%b s%0d d%h expected v1 s%0d d%h", k, out_valid, out_src,
                 out_data, k, 32'h10 + k);
      end
    end
    grant = '0;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: got v%b pending %0d expected v0 pending 0", out_valid, sb.size());
    end
  endtask

  task automatic test_grant_err();
    checks++;
    if (grant_err !== 1'b0) begin
      errors++; $display("FAIL gerr_initial: got %b expected 0", grant_err);
    end
    set_flit(0, 32'hD0); set_flit(1, 32'hD1);
    cycle();
    in_valid = '0; grant = 4'b0011;
    #1;
    checks++;
    if (request !== 4'b0011) begin
      errors++; $display("FAIL gerr_req: got %b expected 0011", request);
    end
    cycle();
    checks++;
    if ({out_src, out_data, grant_err} !== {2'd0, 32'hD0, 1'b1}) begin
      errors++;
      $display("FAIL gerr_multi: got s%0d d%h e%b expected s0 d000000d0 e1", out_src, out_data,
               grant_err);
    end
    grant = 4'b1000;
    #1;
    checks++;
    if (request !== 4'b0010) begin
      errors++; $display("FAIL gerr_retained: got %b expected 0010", request);
    end
    cycle();
    checks++;
    if ({out_valid, grant_err} !== 2'b01) begin
      errors++; $display("FAIL gerr_spurious: got v%b e%b expected v0 e1", out_valid, grant_err);
    end
    grant = 4'b0010;
    cycle();
    checks++;
    if ({out_valid, out_src, out_data} !== {1'b1, 2'd1, 32'hD1}) begin
      errors++;
      $display("FAIL gerr_agent1: got v%b s%0d d%h expected v1 s1 d000000d1", out_valid, out_src,
               out_data);
    end
    grant = '0;
    cycle();
    checks++;
    if (sb.size() != 0 || grant_err !== 1'b1) begin
      errors++;
      $display("FAIL gerr_end: got pending %0d e%b expected pending 0 e1", sb.size(), grant_err);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_flit(0, 32'hE0); set_flit(1, 32'hE2);
    cycle();
    set_flit(0, 32'hE1); set_flit(1, 32'hE3);
    cycle();
    in_valid = '0; grant = 4'b0001;
    cycle();
    grant = '0;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 32'hE0}) begin
      errors++; $display("FAIL rmid_loaded: got v%b d%h expected v1 d000000e0", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({request, in_ready} !== 8'h00) begin
      errors++; $display("FAIL rmid_during: got %b expected 00000000", {request, in_ready});
    end
    cycle();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, grant_err, request, in_ready} !== {1'b0, 32'h0, 1'b0, 4'h0, 4'hF})
    begin
      errors++;
      $display("FAIL rmid_after: got v%b d%h e%b r%b rdy%b expected v0 d0 e0 r0000 rdy1111",
               out_valid, out_data, grant_err, request, in_ready);
    end
    cycle();
    checks++;
    if ({out_valid, request} !== 5'b0) begin
      errors++; $display("FAIL rmid_empty: got v%b r%b expected v0 r0000", out_valid, request);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_stall();
    test_starve();
    test_back_to_back();
    test_grant_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
